// File: rtl/rx_frame_if.sv
// Handshake/bus bundle between the I2C Rx shifter, the frame register and the frame decoder.
// master drives the receive strobes and the ack; slave is the frame register.
interface rx_frame_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PAYLOAD_BYTES = 4
);
  localparam int unsigned CntW = $clog2(PAYLOAD_BYTES + 3);

  logic                                  load_rx;
  logic [DATA_WIDTH-1:0]                 rx_data;
  logic                                  rx_stop;
  logic                                  frame_ack;
  logic [DATA_WIDTH-1:0]                 command;
  logic [PAYLOAD_BYTES*DATA_WIDTH-1:0]   payload;
  logic                                  frame_valid;
  logic                                  busy;
  logic [CntW-1:0]                       byte_count;
  logic                                  frame_err;
  logic                                  overrun;

  modport master (
    output load_rx, rx_data, rx_stop, frame_ack,
    input  command, payload, frame_valid, busy, byte_count, frame_err, overrun
  );

  modport slave (
    input  load_rx, rx_data, rx_stop, frame_ack,
    output command, payload, frame_valid, busy, byte_count, frame_err, overrun
  );
endinterface

// File: rtl/rx_frame_reg.sv
// Receive-frame register: assembles command + PAYLOAD_BYTES words, holds them under valid/ack.
// Optional trailing XOR checksum word enabled by defining RX_FRAME_CHECKSUM_EN.
module rx_frame_reg #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PAYLOAD_BYTES = 4
) (
  input logic       clk,
  input logic       rst,
  rx_frame_if.slave bus
);
  localparam int unsigned CntW = $clog2(PAYLOAD_BYTES + 3);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] LastCnt = CntW'(PAYLOAD_BYTES);

`ifdef RX_FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StPayload, StCheck, StHold} state_e;
`else
  typedef enum logic [1:0] {StIdle, StPayload, StHold} state_e;
`endif

  state_e                              state_q;
  logic [DATA_WIDTH-1:0]               command_q;
  logic [PAYLOAD_BYTES*DATA_WIDTH-1:0] payload_q;
  logic [PAYLOAD_BYTES*DATA_WIDTH-1:0] payload_wr;
  logic [CntW-1:0]                     count_q;
  logic                                valid_q;
  logic                                busy_q;
  logic                                err_q;
  logic                                overrun_q;
  logic                                last_slot;

  assign last_slot = (count_q == LastCnt);

  // Payload image with the incoming word placed in slot byte_count-1.
  always_comb begin
    payload_wr = payload_q;
    for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
      if (count_q == CntW'(i + 1)) begin
        payload_wr[i*DATA_WIDTH +: DATA_WIDTH] = bus.rx_data;
      end
    end
  end

`ifdef RX_FRAME_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
  always_comb begin
    csum = command_q;
    for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
      csum = csum ^ payload_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      command_q <= '0;
      payload_q <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.load_rx) begin
            command_q <= bus.rx_data;
            count_q   <= CntOne;
            busy_q    <= 1'b1;
            state_q   <= StPayload;
          end
        end
        StPayload: begin
          // A stop alongside the final word still completes the frame.
          if (bus.load_rx && last_slot) begin
            payload_q <= payload_wr;
            count_q   <= count_q + CntOne;
`ifdef RX_FRAME_CHECKSUM_EN
            state_q   <= StCheck;
`else
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= StHold;
`endif
          end else if (bus.rx_stop) begin
            err_q   <= 1'b1;
            count_q <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (bus.load_rx) begin
            payload_q <= payload_wr;
            count_q   <= count_q + CntOne;
          end
        end
`ifdef RX_FRAME_CHECKSUM_EN
        StCheck: begin
          if (bus.load_rx && (bus.rx_data == csum)) begin
            count_q <= count_q + CntOne;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= StHold;
          end else if (bus.load_rx || bus.rx_stop) begin
            err_q   <= 1'b1;
            count_q <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
`endif
        StHold: begin
          if (bus.frame_ack) begin
            valid_q <= 1'b0;
            if (bus.load_rx) begin
              command_q <= bus.rx_data;
              count_q   <= CntOne;
              busy_q    <= 1'b1;
              state_q   <= StPayload;
            end else begin
              count_q <= '0;
              state_q <= StIdle;
            end
          end else if (bus.load_rx) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.command     = command_q;
  assign bus.payload     = payload_q;
  assign bus.frame_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.byte_count  = count_q;
  assign bus.frame_err   = err_q;
  assign bus.overrun     = overrun_q;

  a_busy_valid_excl: assert property (@(posedge clk) disable iff (rst) !(busy_q && valid_q));
  a_err_one_cycle:   assert property (@(posedge clk) disable iff (rst) err_q |=> !err_q);

endmodule

// File: tb/tb_rx_frame_reg.sv
// Table-driven self-checking bench for rx_frame_reg (DATA_WIDTH=8, PAYLOAD_BYTES=4).
module tb_rx_frame_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_frame_if #(.DATA_WIDTH(8), .PAYLOAD_BYTES(4)) bus ();

  rx_frame_reg #(.DATA_WIDTH(8), .PAYLOAD_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        r, ld, st, ak;
    logic [7:0]  d;
    logic        ev, eb;
    logic [2:0]  ec;
    logic        ee, eo;
    logic        ccmd;
    logic [7:0]  ecmd;
    logic        cpay;
    logic [31:0] epay;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int fails = 0;

  task automatic add(input logic r, ld, st, ak, input logic [7:0] d,
                     input logic ev, eb, input logic [2:0] ec, input logic ee, eo,
                     input logic ccmd, input logic [7:0] ecmd,
                     input logic cpay, input logic [31:0] epay);
    vec_t v;
    v.r = r; v.ld = ld; v.st = st; v.ak = ak; v.d = d;
    v.ev = ev; v.eb = eb; v.ec = ec; v.ee = ee; v.eo = eo;
    v.ccmd = ccmd; v.ecmd = ecmd; v.cpay = cpay; v.epay = epay;
    vecs.push_back(v);
  endtask

  task automatic chk(input int idx, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL step %0d %s: got %0h expected %0h", idx, nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, ld, st, ak, input logic [7:0] d);
    rst = r; bus.load_rx = ld; bus.rx_stop = st; bus.frame_ack = ak; bus.rx_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input int idx, input logic ev, eb, input logic [2:0] ec,
                            input logic ee, eo);
    chk(idx, "frame_valid", 32'(bus.frame_valid), 32'(ev));
    chk(idx, "busy",        32'(bus.busy),        32'(eb));
    chk(idx, "byte_count",  32'(bus.byte_count),  32'(ec));
    chk(idx, "frame_err",   32'(bus.frame_err),   32'(ee));
    chk(idx, "overrun",     32'(bus.overrun),     32'(eo));
  endtask

  logic [7:0] seq [$];

  initial begin
    bus.load_rx = 1'b0; bus.rx_stop = 1'b0; bus.frame_ack = 1'b0; bus.rx_data = '0;
    //   r ld st ak data   ev eb cnt ee eo  ccmd cmd  cpay payload
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h00, 1, 32'h0);
`ifndef RX_FRAME_CHECKSUM_EN
    add(0, 1, 0, 0, 8'hA5, 0, 1, 1, 0, 0, 1, 8'hA5, 1, 32'h0);
    add(0, 1, 0, 0, 8'h01, 0, 1, 2, 0, 0, 1, 8'hA5, 1, 32'h00000001);
    add(0, 1, 0, 0, 8'h02, 0, 1, 3, 0, 0, 1, 8'hA5, 1, 32'h00000201);
    add(0, 1, 0, 0, 8'h03, 0, 1, 4, 0, 0, 1, 8'hA5, 1, 32'h00030201);
    add(0, 1, 0, 0, 8'h04, 1, 0, 5, 0, 0, 1, 8'hA5, 1, 32'h04030201);
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 0, 8'h00, 1, 0, 5, 0, 0, 1, 8'hA5, 1, 32'h04030201);
    add(0, 1, 0, 0, 8'h77, 1, 0, 5, 0, 1, 1, 8'hA5, 1, 32'h04030201);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 1, 8'hA5, 1, 32'h04030201);
    add(0, 1, 0, 0, 8'h10, 0, 1, 1, 0, 1, 1, 8'h10, 0, 32'h0);
    add(0, 1, 0, 0, 8'h11, 0, 1, 2, 0, 1, 1, 8'h10, 0, 32'h0);
    add(0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 0, 32'h0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 32'h0);
    add(0, 1, 0, 0, 8'h20, 0, 1, 1, 0, 1, 1, 8'h20, 0, 32'h0);
    add(0, 1, 0, 0, 8'h21, 0, 1, 2, 0, 1, 1, 8'h20, 0, 32'h0);
    add(0, 1, 0, 0, 8'h22, 0, 1, 3, 0, 1, 1, 8'h20, 0, 32'h0);
    add(0, 1, 0, 0, 8'h23, 0, 1, 4, 0, 1, 1, 8'h20, 0, 32'h0);
    add(0, 1, 0, 0, 8'h24, 1, 0, 5, 0, 1, 1, 8'h20, 1, 32'h24232221);
    // ack and load together: new command, no overrun change
    add(0, 1, 0, 1, 8'h3C, 0, 1, 1, 0, 1, 1, 8'h3C, 0, 32'h0);
    add(0, 1, 0, 0, 8'h31, 0, 1, 2, 0, 1, 1, 8'h3C, 0, 32'h0);
    add(0, 1, 0, 0, 8'h32, 0, 1, 3, 0, 1, 1, 8'h3C, 0, 32'h0);
    add(0, 1, 0, 0, 8'h33, 0, 1, 4, 0, 1, 1, 8'h3C, 0, 32'h0);
    add(0, 1, 0, 0, 8'h34, 1, 0, 5, 0, 1, 1, 8'h3C, 1, 32'h34333231);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 1, 8'h3C, 1, 32'h34333231);
    // stop with final word: frame completes without error
    add(0, 1, 0, 0, 8'h40, 0, 1, 1, 0, 1, 1, 8'h40, 0, 32'h0);
    add(0, 1, 0, 0, 8'h41, 0, 1, 2, 0, 1, 1, 8'h40, 0, 32'h0);
    add(0, 1, 0, 0, 8'h42, 0, 1, 3, 0, 1, 1, 8'h40, 0, 32'h0);
    add(0, 1, 0, 0, 8'h43, 0, 1, 4, 0, 1, 1, 8'h40, 0, 32'h0);
    add(0, 1, 1, 0, 8'h44, 1, 0, 5, 0, 1, 1, 8'h40, 1, 32'h44434241);
    add(0, 0, 1, 0, 8'h00, 1, 0, 5, 0, 1, 1, 8'h40, 1, 32'h44434241);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 32'h0);
    // stop with non-final word: abort wins
    add(0, 1, 0, 0, 8'h50, 0, 1, 1, 0, 1, 1, 8'h50, 0, 32'h0);
    add(0, 1, 1, 0, 8'h51, 0, 0, 0, 1, 1, 0, 8'h00, 0, 32'h0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 32'h0);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 32'h0);
    // reset mid-payload, then a clean frame
    add(0, 1, 0, 0, 8'h60, 0, 1, 1, 0, 1, 1, 8'h60, 0, 32'h0);
    add(0, 1, 0, 0, 8'h61, 0, 1, 2, 0, 1, 1, 8'h60, 0, 32'h0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h00, 1, 32'h0);
    add(0, 1, 0, 0, 8'h70, 0, 1, 1, 0, 0, 1, 8'h70, 0, 32'h0);
    add(0, 1, 0, 0, 8'h71, 0, 1, 2, 0, 0, 1, 8'h70, 0, 32'h0);
    add(0, 1, 0, 0, 8'h72, 0, 1, 3, 0, 0, 1, 8'h70, 0, 32'h0);
    add(0, 1, 0, 0, 8'h73, 0, 1, 4, 0, 0, 1, 8'h70, 0, 32'h0);
    add(0, 1, 0, 0, 8'h74, 1, 0, 5, 0, 0, 1, 8'h70, 1, 32'h74737271);
    add(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 8'h70, 1, 32'h74737271);
`else
    // checksum word = 80^01^02^03^04 = 84
    for (int rep = 0; rep < 2; rep++) begin
      add(0, 1, 0, 0, 8'h80, 0, 1, 1, 0, 0, 1, 8'h80, 0, 32'h0);
      add(0, 1, 0, 0, 8'h01, 0, 1, 2, 0, 0, 1, 8'h80, 0, 32'h0);
      add(0, 1, 0, 0, 8'h02, 0, 1, 3, 0, 0, 1, 8'h80, 0, 32'h0);
      add(0, 1, 0, 0, 8'h03, 0, 1, 4, 0, 0, 1, 8'h80, 0, 32'h0);
      add(0, 1, 0, 0, 8'h04, 0, 1, 5, 0, 0, 1, 8'h80, 1, 32'h04030201);
      if (rep == 0) begin
        add(0, 1, 0, 0, 8'h84, 1, 0, 6, 0, 0, 1, 8'h80, 1, 32'h04030201);
        add(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 8'h80, 1, 32'h04030201);
      end else begin
        add(0, 1, 0, 0, 8'h81, 0, 0, 0, 1, 0, 0, 8'h00, 0, 32'h0);
        add(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 32'h0);
      end
    end
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].ld, vecs[i].st, vecs[i].ak, vecs[i].d);
      check_outs(i, vecs[i].ev, vecs[i].eb, vecs[i].ec, vecs[i].ee, vecs[i].eo);
      if (vecs[i].ccmd) chk(i, "command", 32'(bus.command), 32'(vecs[i].ecmd));
      if (vecs[i].cpay) chk(i, "payload", bus.payload, vecs[i].epay);
    end

    // Minimum frame period with frame_ack tied high; the next frame starts right after HOLD.
    drive(1, 0, 0, 0, 8'h00);
    seq = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
`ifdef RX_FRAME_CHECKSUM_EN
    seq.push_back(8'hB4);
`endif
    foreach (seq[j]) drive(0, 1, 0, 1, seq[j]);
`ifdef RX_FRAME_CHECKSUM_EN
    check_outs(1000, 1, 0, 6, 0, 0);
`else
    check_outs(1000, 1, 0, 5, 0, 0);
`endif
    chk(1000, "command", 32'(bus.command), 32'h000000B0);
    chk(1000, "payload", bus.payload, 32'hB4B3B2B1);
    drive(0, 1, 0, 1, 8'hC0);
    check_outs(1001, 0, 1, 1, 0, 0);
    chk(1001, "command", 32'(bus.command), 32'h000000C0);

    // Reset overrides a held frame with pending overrun.
    drive(0, 1, 0, 0, 8'hC1);
    drive(0, 1, 0, 0, 8'hC2);
    drive(0, 1, 0, 0, 8'hC3);
    drive(0, 1, 0, 0, 8'hC4);
`ifdef RX_FRAME_CHECKSUM_EN
    drive(0, 1, 0, 0, 8'hC0 ^ 8'hC1 ^ 8'hC2 ^ 8'hC3 ^ 8'hC4);
`endif
    drive(0, 1, 0, 0, 8'h99);
    chk(1002, "overrun", 32'(bus.overrun), 32'd1);
    chk(1002, "frame_valid", 32'(bus.frame_valid), 32'd1);
    drive(1, 1, 1, 1, 8'h55);
    check_outs(1003, 0, 0, 0, 0, 0);
    chk(1003, "command", 32'(bus.command), 32'd0);
    drive(0, 0, 0, 0, 8'h00);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
